// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: shared definitions for the SR-cell bank controller.
//   - op encodings carried on the per-requester op bus
//   - controller FSM state type
//   - pulse counter width (PULSE_W may be 1..15)
//   - idx_width(): width of an index into n items, never below 1
package sr_bank_pkg;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_RESET  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_bank_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req       in  NREQ  request vector
//   ptr       in  IW    highest-priority index this round
//   grant     out NREQ  one-hot grant of the first set req at or after ptr
//   grant_idx out IW    index of that grant
//   any_req   out 1     at least one request is pending
// The pointer register is owned by the caller.
module rr_arbiter
  import sr_bank_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any_req
);

  logic [NREQ-1:0] rot;
  logic [IW-1:0]   off;
  logic [IW:0]     sum;

  always_comb begin
    // Rotate so that bit 0 of rot is req[ptr]; the lowest set bit of rot is
    // then the winner, and its offset is added back to ptr modulo NREQ.
    rot = NREQ'({req, req} >> ptr);
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW + 1)'(NREQ)) sum = sum - (IW + 1)'(NREQ);
    grant_idx = sum[IW-1:0];
    any_req   = |req;
    grant     = any_req ? (NREQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/sr_bank_ctrl.sv
// sr_bank_ctrl: shares a bank of NCELL gated NAND SR cells among NREQ
// requesters. Each granted operation (READ/SET/RESET/TOGGLE) is applied to
// one cell with a setup / enable-pulse / hold sequence on s/r, and the cell's
// resulting q is returned with done. s and r are never both driven.
//   clock    in  1         rising-edge clock
//   rst_n    in  1         synchronous active-low reset
//   req      in  NREQ      per-requester request, held until gnt
//   op       in  2*NREQ    requester i op in [2i+1:2i]
//   addr     in  AW*NREQ   requester i cell index in slice i
//   gnt      out NREQ      one-hot single-cycle grant
//   done     out NREQ      one-hot single-cycle completion
//   rdata    out 1         cell q after the operation, valid with done
//   err      out 1         address out of range, valid with done
//   busy     out 1         high from grant through done
//   cell_s   out NCELL     per-cell s drive
//   cell_r   out NCELL     per-cell r drive
//   cell_en  out NCELL     per-cell gate enable
//   cell_q   in  NCELL     per-cell q readback
// Every output is registered: the value computed for a state becomes visible
// one cycle later, which gives write grant-to-done = 3+PULSE_W and
// read/error grant-to-done = 2.
module sr_bank_ctrl
  import sr_bank_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int NCELL   = 8,
  parameter int AW      = $clog2(NCELL),
  parameter int PULSE_W = 1
) (
  input  logic                 clock,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    op,
  input  logic [AW*NREQ-1:0]   addr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 rdata,
  output logic                 err,
  output logic                 busy,
  output logic [NCELL-1:0]     cell_s,
  output logic [NCELL-1:0]     cell_r,
  output logic [NCELL-1:0]     cell_en,
  input  logic [NCELL-1:0]     cell_q
);

  localparam int IW = idx_width(NREQ);

  state_t           state_reg, state_next;
  logic [IW-1:0]    ptr_reg, ptr_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [1:0]       op_reg, op_next;
  logic [AW-1:0]    addr_reg, addr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [NREQ-1:0]  gnt_next, done_next;
  logic             rdata_next, err_next, busy_next;
  logic [NCELL-1:0] cell_s_next, cell_r_next, cell_en_next;

  logic [1:0]       op_arr   [NREQ];
  logic [AW-1:0]    addr_arr [NREQ];
  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             any_req;

  // One-hot decode of the captured address; all-zero when out of range, so
  // it doubles as the range check and as a safe cell_q selector.
  logic [NCELL-1:0] addr_sel;
  logic             in_range;
  logic             q_sel;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign op_arr[gi]   = op[2*gi +: 2];
      assign addr_arr[gi] = addr[AW*gi +: AW];
    end
    for (gi = 0; gi < NCELL; gi++) begin : g_dec
      assign addr_sel[gi] = (addr_reg == AW'(gi));
    end
  endgenerate

  assign in_range = |addr_sel;
  assign q_sel    = |(cell_q & addr_sel);

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req       (req),
    .ptr       (ptr_reg),
    .grant     (arb_gnt),
    .grant_idx (arb_idx),
    .any_req   (any_req)
  );

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
      op_reg    <= OP_READ;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      gnt       <= '0;
      done      <= '0;
      rdata     <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cell_s    <= '0;
      cell_r    <= '0;
      cell_en   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      gnt       <= gnt_next;
      done      <= done_next;
      rdata     <= rdata_next;
      err       <= err_next;
      busy      <= busy_next;
      cell_s    <= cell_s_next;
      cell_r    <= cell_r_next;
      cell_en   <= cell_en_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    owner_next   = owner_reg;
    op_next      = op_reg;
    addr_next    = addr_reg;
    cnt_next     = cnt_reg;
    gnt_next     = '0;
    done_next    = '0;
    rdata_next   = 1'b0;
    err_next     = 1'b0;
    busy_next    = busy;
    cell_s_next  = cell_s;
    cell_r_next  = cell_r;
    cell_en_next = '0;

    unique case (state_reg)
      IDLE: begin
        busy_next = any_req;
        if (any_req) begin
          gnt_next   = arb_gnt;
          owner_next = arb_idx;
          op_next    = op_arr[arb_idx];
          addr_next  = addr_arr[arb_idx];
          ptr_next   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_next = '0;
        if (!in_range || op_reg == OP_READ) begin
          state_next = DONE;
        end else begin
          // Exactly one of s/r is driven, which is what keeps S=R=1 away
          // from every cell.
          unique case (op_reg)
            OP_SET:   cell_s_next = addr_sel;
            OP_RESET: cell_r_next = addr_sel;
            default: begin
              if (q_sel) cell_r_next = addr_sel;
              else       cell_s_next = addr_sel;
            end
          endcase
          state_next = PULSE;
        end
      end
      PULSE: begin
        cell_en_next = addr_sel;
        if (cnt_reg == CNT_W'(PULSE_W - 1)) state_next = HOLD;
        else                                 cnt_next   = cnt_reg + 1'b1;
      end
      HOLD: begin
        state_next = DONE;
      end
      DONE: begin
        cell_s_next = '0;
        cell_r_next = '0;
        done_next   = NREQ'(1) << owner_reg;
        rdata_next  = q_sel;
        err_next    = !in_range;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr_bank_ctrl.sv
// tb_sr_bank_ctrl: directed bench for sr_bank_ctrl. Two instances share the
// clock and reset: dut1 (PULSE_W=1, AW=4 so that address 9 is expressible)
// carries the main sequence, dut4 (PULSE_W=4) the reset-in-pulse case. Each
// has a behavioural gated NAND SR bank and a per-cycle invariant monitor.
module tb_sr_bank_ctrl;
  import sr_bank_pkg::*;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic [3:0]  req1 = '0;
  logic [7:0]  op1 = '0;
  logic [15:0] addr1 = '0;
  logic [3:0]  gnt1, done1;
  logic        rdata1, err1, busy1;
  logic [7:0]  s1, r1, en1;
  logic [7:0]  q1 = '0;

  logic [3:0]  req4 = '0;
  logic [7:0]  op4 = '0;
  logic [11:0] addr4 = '0;
  logic [3:0]  gnt4, done4;
  logic        rdata4, err4, busy4;
  logic [7:0]  s4, r4, en4;
  logic [7:0]  q4 = '0;

  int total = 0;
  int passed = 0;

  sr_bank_ctrl #(.NREQ(4), .NCELL(8), .AW(4), .PULSE_W(1)) dut1 (
    .clock(clock), .rst_n(rst_n), .req(req1), .op(op1), .addr(addr1),
    .gnt(gnt1), .done(done1), .rdata(rdata1), .err(err1), .busy(busy1),
    .cell_s(s1), .cell_r(r1), .cell_en(en1), .cell_q(q1)
  );

  sr_bank_ctrl #(.NREQ(4), .NCELL(8), .AW(3), .PULSE_W(4)) dut4 (
    .clock(clock), .rst_n(rst_n), .req(req4), .op(op4), .addr(addr4),
    .gnt(gnt4), .done(done4), .rdata(rdata4), .err(err4), .busy(busy4),
    .cell_s(s4), .cell_r(r4), .cell_en(en4), .cell_q(q4)
  );

  // Gated SR cells: transparent while en is high; S=R=1 poisons q with X.
  always @(negedge clock) begin
    for (int k = 0; k < 8; k++) begin
      if (en1[k]) begin
        if (s1[k] && r1[k]) q1[k] <= 1'bx;
        else if (s1[k])     q1[k] <= 1'b1;
        else if (r1[k])     q1[k] <= 1'b0;
      end
      if (en4[k]) begin
        if (s4[k] && r4[k]) q4[k] <= 1'bx;
        else if (s4[k])     q4[k] <= 1'b1;
        else if (r4[k])     q4[k] <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // bit0: s&r, bit1: more than one cell touched, bit2: en without s/r,
  // bit3: s/r changed while en stayed high.
  function automatic logic [3:0] inv_bits(input logic [7:0] s, r, en, ps, pr, pen);
    logic [3:0] v;
    v[0] = |(s & r);
    v[1] = !$onehot0(s | r | en);
    v[2] = |(en & ~(s | r));
    v[3] = (|(en & pen)) && ((s != ps) || (r != pr));
    return v;
  endfunction

  logic [7:0] ps1 = '0, pr1 = '0, pen1 = '0;
  logic [7:0] ps4 = '0, pr4 = '0, pen4 = '0;
  always @(negedge clock) begin
    chk("inv_dut1", 32'(inv_bits(s1, r1, en1, ps1, pr1, pen1)), 0);
    chk("inv_dut4", 32'(inv_bits(s4, r4, en4, ps4, pr4, pen4)), 0);
    ps1 <= s1; pr1 <= r1; pen1 <= en1;
    ps4 <= s4; pr4 <= r4; pen4 <= en4;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d passed=%0d", total, passed);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic req_on1(input int i, input logic [1:0] o, input logic [3:0] a);
    op1[2*i +: 2]   = o;
    addr1[4*i +: 4] = a;
    req1[i]         = 1'b1;
  endtask

  task automatic wait_gnt1(input string tag, input logic [3:0] exp);
    int n = 0;
    while (gnt1 == '0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(gnt1), 32'(exp));
  endtask

  task automatic wait_done1(input string tag, input logic [3:0] exp_done, input logic exp_rd,
                            input logic exp_err);
    int n = 0;
    while (done1 == '0 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'({done1, rdata1, err1}), 32'({exp_done, exp_rd, exp_err}));
    $display("dut1 txn: done=%b rdata=%b err=%b", done1, rdata1, err1);
  endtask

  logic [3:0] ctn_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] ctn_addr[4] = '{4'd0, 4'd1, 4'd2, 4'd4};

  initial begin
    int n;
    logic seen;

    // Reset for two cycles, then idle.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_gnt",   32'(gnt1), 0);
    chk("rst_done",  32'(done1), 0);
    chk("rst_busy",  32'(busy1), 0);
    chk("rst_cells", 32'({s1, r1, en1}), 0);
    chk("rst_dut4",  32'({gnt4, done4, busy4, s4, r4, en4}), 0);

    // Single SET of cell 3 by requester 0.
    req_on1(0, OP_SET, 4'd3);
    tick();
    chk("set_gnt",  32'(gnt1), 32'h1);
    chk("set_busy", 32'(busy1), 1);
    req1 = '0;
    tick(); chk("set_setup", 32'({s1, r1, en1}), 32'h08_00_00);
    tick(); chk("set_pulse", 32'({s1, r1, en1}), 32'h08_00_08);
    tick(); chk("set_hold",  32'({s1, r1, en1}), 32'h08_00_00);
    tick();
    chk("set_done",       32'({done1, rdata1, err1}), 32'b0001_1_0);
    chk("set_done_cells", 32'({s1, r1, en1}), 0);
    chk("set_done_busy",  32'(busy1), 1);
    $display("dut1 txn: SET cell3 done=%b rdata=%b", done1, rdata1);
    tick();
    chk("set_idle_busy", 32'(busy1), 0);

    // TOGGLE cell 5 twice (starts at 0): s first, then r.
    req_on1(1, OP_TOGGLE, 4'd5);
    tick(); chk("tgl1_gnt", 32'(gnt1), 32'h2);
    req1 = '0;
    tick(); chk("tgl1_drive", 32'({s1, r1}), 32'h20_00);
    tick(); tick(); tick();
    chk("tgl1_done", 32'({done1, rdata1, err1}), 32'b0010_1_0);
    $display("dut1 txn: TOGGLE cell5 rdata=%b", rdata1);
    tick();
    req_on1(1, OP_TOGGLE, 4'd5);
    tick(); chk("tgl2_gnt", 32'(gnt1), 32'h2);
    req1 = '0;
    tick(); chk("tgl2_drive", 32'({s1, r1}), 32'h00_20);
    tick(); tick(); tick();
    chk("tgl2_done", 32'({done1, rdata1, err1}), 32'b0010_0_0);
    $display("dut1 txn: TOGGLE cell5 rdata=%b", rdata1);
    tick();

    // READ of cell 3 (set earlier): no cell activity, rdata=1.
    req_on1(2, OP_READ, 4'd3);
    tick(); chk("rd_gnt", 32'(gnt1), 32'h4);
    req1 = '0;
    tick(); chk("rd_quiet", 32'({s1, r1, en1}), 0);
    tick();
    chk("rd_done",       32'({done1, rdata1, err1}), 32'b0100_1_0);
    chk("rd_done_cells", 32'({s1, r1, en1}), 0);
    $display("dut1 txn: READ cell3 rdata=%b", rdata1);
    tick();

    // Out-of-range address 9: error after 2 cycles, nothing driven.
    req_on1(3, OP_SET, 4'd9);
    tick(); chk("err_gnt", 32'(gnt1), 32'h8);
    req1 = '0;
    tick(); chk("err_quiet", 32'({s1, r1, en1}), 0);
    tick();
    chk("err_done",       32'({done1, rdata1, err1}), 32'b1000_0_1);
    chk("err_done_cells", 32'({s1, r1, en1}), 0);
    $display("dut1 txn: SET addr9 err=%b rdata=%b", err1, rdata1);
    tick();

    // Contention: all four request; requester 0 stays up for a second turn.
    for (int i = 0; i < 4; i++) req_on1(i, OP_SET, ctn_addr[i]);
    for (int k = 0; k < 5; k++) begin
      wait_gnt1($sformatf("ctn_gnt%0d", k), ctn_exp[k]);
      if (k != 0) req1 = req1 & ~gnt1;
      wait_done1($sformatf("ctn_done%0d", k), ctn_exp[k], 1'b1, 1'b0);
    end
    chk("ctn_req_clear", 32'(req1), 0);
    tick(); tick();
    chk("ctn_quiet", 32'({gnt1, busy1}), 0);

    // dut4: reset during the second cycle of a 4-cycle enable pulse.
    op4[5:4]   = OP_SET;
    addr4[8:6] = 3'd6;
    req4       = 4'b0100;
    tick(); chk("mid_gnt", 32'(gnt4), 32'h4);
    req4 = '0;
    tick(); chk("mid_setup",  32'({s4, r4, en4}), 32'h40_00_00);
    tick(); chk("mid_pulse1", 32'({s4, r4, en4}), 32'h40_00_40);
    tick(); chk("mid_pulse2", 32'({s4, r4, en4}), 32'h40_00_40);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_cells", 32'({s4, r4, en4}), 0);
    chk("mid_rst_flags", 32'({gnt4, done4, busy4}), 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen = seen | (|done4);
    end
    chk("mid_no_done", 32'(seen), 0);
    $display("dut4 txn: SET cell6 abandoned by reset");

    // Pointer back at 0: requesters 1 and 3 pending, 1 must win.
    op4[3:2]    = OP_SET;
    addr4[5:3]  = 3'd1;
    op4[7:6]    = OP_SET;
    addr4[11:9] = 3'd7;
    req4        = 4'b1010;
    tick(); chk("post_rst_gnt", 32'(gnt4), 32'h2);
    req4 = '0;
    n = 0;
    while (done4 == '0 && n < 20) begin
      tick();
      n++;
    end
    chk("post_rst_done", 32'({done4, rdata4, err4}), 32'b0010_1_0);
    chk("post_rst_lat",  32'(n), 7);
    $display("dut4 txn: SET cell1 done=%b rdata=%b", done4, rdata4);

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
